fpga_rst_seq: RTL

- Reset sequencer between the clock-wizard `locked` output and the RT-SS `rst_ni` input in board FPGA wrappers.
- Replaces the direct `locked`-to-reset tie with three stages: a synchronised, glitch-filtered lock qualifier; a debounced push-button reset request; and a fixed minimum reset hold.
- Clocked by the free-running board clock; its output is held long enough for rt_top's internal reset synchroniser in the top_clk domain.

---
 rtl/fpga_rst_seq_pkg.sv | 17 +
 rtl/fpga_rst_seq_debounce.sv | 59 +++++
 rtl/fpga_rst_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fpga_rst_seq_pkg.sv
// Shared types and constants for the board reset sequencer.
package fpga_rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        FILTER = 2'd1,
        HOLD   = 2'd2,
        RUN    = 2'd3
    } rst_seq_state_e;

    localparam int LockLossCntWidth = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fpga_rst_seq_debounce.sv
// Synchroniser chain followed by a counting debouncer for an asynchronous, bouncy request line.
module fpga_rst_seq_debounce
    import fpga_rst_seq_pkg::*;
#(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic req_db_o
);

    localparam int DbW = $clog2(DebounceCycles + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q;
    logic [SyncStages-1:0] sync_d;
    logic                  req_s;
    logic                  req_db_q;
    logic                  req_db_d;
    logic [DbW-1:0]        cnt_db_q;
    logic [DbW-1:0]        cnt_db_d;

    assign sync_d[0] = async_i;
    for (genvar gi = 1; gi < SyncStages; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end
    assign req_s = sync_q[SyncStages-1];

    // The debounced level only follows req_s after it has differed for DebounceCycles edges in a row.
    always_comb begin
        req_db_d = req_db_q;
        cnt_db_d = cnt_db_q;
        if (req_s == req_db_q) begin
            cnt_db_d = '0;
        end else if (cnt_db_q == DbLast) begin
            req_db_d = req_s;
            cnt_db_d = '0;
        end else begin
            cnt_db_d = cnt_db_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            req_db_q <= 1'b0;
            cnt_db_q <= '0;
        end else begin
            sync_q   <= sync_d;
            req_db_q <= req_db_d;
            cnt_db_q <= cnt_db_d;
        end
    end

    assign req_db_o = req_db_q;

endmodule

// File: rtl/fpga_rst_seq.sv
// Reset sequencer: qualifies PLL lock, debounces the push-button request and holds rt_top in reset.
// Define FPGA_RST_SEQ_STATUS_EN to add the saturating lock-loss counter output lock_loss_cnt_o.
module fpga_rst_seq
    import fpga_rst_seq_pkg::*;
#(
    parameter int SyncStages       = 2,
    parameter int LockFilterCycles = 16,
    parameter int HoldCycles       = 64,
    parameter int DebounceCycles   = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       ext_rst_req_i,
    output logic       rst_no,
    output logic       ready_o,
    output logic [1:0] state_o
`ifdef FPGA_RST_SEQ_STATUS_EN
    ,
    output logic [LockLossCntWidth-1:0] lock_loss_cnt_o
`endif
);

    localparam int CntW = $clog2(max_int(LockFilterCycles, HoldCycles) + 1);
    localparam logic [CntW-1:0] FilterLast = CntW'(LockFilterCycles - 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(HoldCycles - 1);

    logic [SyncStages-1:0] lock_sync_q;
    logic [SyncStages-1:0] lock_sync_d;
    logic                  locked_s;
    logic                  req_db;
    logic                  abort;

    rst_seq_state_e        state_q;
    rst_seq_state_e        state_d;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_d;
    logic                  rst_n_q;
    logic                  rst_n_d;
    logic                  ready_q;
    logic                  ready_d;

    assign lock_sync_d[0] = locked_i;
    for (genvar gi = 1; gi < SyncStages; gi++) begin : g_lock_sync
        assign lock_sync_d[gi] = lock_sync_q[gi-1];
    end
    assign locked_s = lock_sync_q[SyncStages-1];

    fpga_rst_seq_debounce #(
        .SyncStages     (SyncStages),
        .DebounceCycles (DebounceCycles)
    ) u_req_debounce (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .async_i  (ext_rst_req_i),
        .req_db_o (req_db)
    );

    assign abort = !locked_s || req_db;

    // Abort is checked before counter completion so it always wins on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ASSERT: begin
                cnt_d = '0;
                if (!abort) begin
                    state_d = FILTER;
                end
            end
            FILTER: begin
                if (abort) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == FilterLast) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (abort) begin
                    state_d = ASSERT;
                end
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
            end
        endcase
        // Outputs are decoded from the next state so they change on the same edge as the state.
        rst_n_d = (state_d == RUN);
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
            state_q     <= ASSERT;
            cnt_q       <= '0;
            rst_n_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_n_q     <= rst_n_d;
            ready_q     <= ready_d;
        end
    end

    assign rst_no  = rst_n_q;
    assign ready_o = ready_q;
    assign state_o = state_q;

`ifdef FPGA_RST_SEQ_STATUS_EN
    logic [LockLossCntWidth-1:0] loss_cnt_q;
    logic [LockLossCntWidth-1:0] loss_cnt_d;

    // Only exits from RUN with the lock actually gone are counted; button-only resets are not.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (state_q == RUN && state_d == ASSERT && !locked_s && loss_cnt_q != '1) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule
